// File: rtl/rtc_bus_master.sv
// rtc_bus_master: drives an external RTC chip over a multiplexed 8-bit
// address/data bus. A write request pushes the registers selected by
// habilita to the chip in ascending index order. A read request fetches all
// nine chip registers and publishes them together on the *le outputs.
// Optional build macro: RTC_XFER_CMD_EN appends an address-only access to
// ADDR_XFER after every write sequence that moved at least one register.
//
// Handshake: start_wr/start_rd are one-cycle requests that are only honoured
// while busy=0. busy rises on the edge that accepts a request and falls on
// the edge that returns to IDLE. listo_es pulses for exactly one cycle when
// the sequence completes. start_wr wins if both requests arrive together.
module rtc_bus_master #(
    parameter int         T_PH      = 2,
    parameter logic [7:0] ADDR_XFER = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_wr,
    input  logic       start_rd,
    input  logic [8:0] habilita,
    input  logic [7:0] ano,
    input  logic [7:0] mes,
    input  logic [7:0] dia,
    input  logic [7:0] hora,
    input  logic [7:0] min,
    input  logic [7:0] seg,
    input  logic [7:0] ht,
    input  logic [7:0] mt,
    input  logic [7:0] st,
    output logic [7:0] anole,
    output logic [7:0] mesle,
    output logic [7:0] diale,
    output logic [7:0] horale,
    output logic [7:0] minle,
    output logic [7:0] segle,
    output logic [7:0] htle,
    output logic [7:0] mtle,
    output logic [7:0] stle,
    output logic       listo_es,
    output logic       busy,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [3:0] state_dbg
);

    localparam int CW = (T_PH > 1) ? $clog2(T_PH) : 1;
    localparam logic [CW-1:0] PH_LAST = CW'(T_PH - 1);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_ADDR_SETUP  = 4'd1,
        S_ADDR_STROBE = 4'd2,
        S_ADDR_HOLD   = 4'd3,
        S_DATA_SETUP  = 4'd4,
        S_DATA_STROBE = 4'd5,
        S_DATA_HOLD   = 4'd6,
        S_GAP         = 4'd7,
        S_DONE        = 4'd8
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ph_q, ph_d;
    logic [3:0]      idx_q, idx_d;
    logic            op_rd_q, op_rd_d;
    logic            xfer_q, xfer_d;
    logic [8:0]      mask_q, mask_d;
    logic [8:0][7:0] wdata_q, wdata_d;
    logic [8:0][7:0] shadow_q, shadow_d;
    logic [8:0][7:0] rb_q, rb_d;

    logic [8:0][7:0] wdata_in;
    logic            phase_state;
    logic            phase_last;
    logic [4:0]      first_sel;
    logic [4:0]      next_idx;

    // Chip register address for each index (time block, then timer block).
    function automatic logic [7:0] addr_of(input logic [3:0] idx);
        logic [7:0] a;
        case (idx)
            4'd0:    a = 8'h21;
            4'd1:    a = 8'h22;
            4'd2:    a = 8'h23;
            4'd3:    a = 8'h24;
            4'd4:    a = 8'h25;
            4'd5:    a = 8'h26;
            4'd6:    a = 8'h41;
            4'd7:    a = 8'h42;
            4'd8:    a = 8'h43;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Lowest set mask bit at or above 'from'; bit 4 of the result flags a hit.
    function automatic logic [4:0] next_sel(input logic [8:0] m, input logic [3:0] from);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 8; i >= 0; i--) begin
            if (m[i] && (4'(i) >= from)) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    assign wdata_in    = {ht, mt, st, ano, mes, dia, hora, min, seg};
    assign phase_state = (state_q != S_IDLE) && (state_q != S_GAP) && (state_q != S_DONE);
    assign phase_last  = (ph_q == PH_LAST);
    assign first_sel   = next_sel(habilita, 4'd0);
    assign next_idx    = next_sel(mask_q, idx_q + 4'd1);

    // State and datapath registers; reset puts the bus straight back to idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ph_q     <= '0;
            idx_q    <= '0;
            op_rd_q  <= 1'b0;
            xfer_q   <= 1'b0;
            mask_q   <= '0;
            wdata_q  <= '0;
            shadow_q <= '0;
            rb_q     <= '0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            idx_q    <= idx_d;
            op_rd_q  <= op_rd_d;
            xfer_q   <= xfer_d;
            mask_q   <= mask_d;
            wdata_q  <= wdata_d;
            shadow_q <= shadow_d;
            rb_q     <= rb_d;
        end
    end

    // Next-state: phase timing, index walk, snapshot, capture and publish.
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        idx_d    = idx_q;
        op_rd_d  = op_rd_q;
        xfer_d   = xfer_q;
        mask_d   = mask_q;
        wdata_d  = wdata_q;
        shadow_d = shadow_q;
        rb_d     = rb_q;

        if (phase_state) begin
            ph_d = phase_last ? '0 : ph_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                ph_d   = '0;
                xfer_d = 1'b0;
                if (start_wr || start_rd) begin
                    wdata_d = wdata_in;
                    op_rd_d = !start_wr;
                    mask_d  = start_wr ? habilita : 9'h1FF;
                end
                if (start_wr) begin
                    if (first_sel[4]) begin
                        idx_d   = first_sel[3:0];
                        state_d = S_ADDR_SETUP;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (start_rd) begin
                    idx_d   = 4'd0;
                    state_d = S_ADDR_SETUP;
                end
            end
            S_ADDR_SETUP:  if (phase_last) state_d = S_ADDR_STROBE;
            S_ADDR_STROBE: if (phase_last) state_d = S_ADDR_HOLD;
            S_ADDR_HOLD:   if (phase_last) state_d = xfer_q ? S_GAP : S_DATA_SETUP;
            S_DATA_SETUP:  if (phase_last) state_d = S_DATA_STROBE;
            S_DATA_STROBE: begin
                if (phase_last) begin
                    state_d = S_DATA_HOLD;
                    if (op_rd_q) shadow_d[idx_q] = ad_in;
                end
            end
            S_DATA_HOLD:   if (phase_last) state_d = S_GAP;
            S_GAP: begin
                if (next_idx[4]) begin
                    idx_d   = next_idx[3:0];
                    state_d = S_ADDR_SETUP;
                end
`ifdef RTC_XFER_CMD_EN
                else if (!op_rd_q && !xfer_q) begin
                    xfer_d  = 1'b1;
                    state_d = S_ADDR_SETUP;
                end
`endif
                else begin
                    state_d = S_DONE;
                    if (op_rd_q) rb_d = shadow_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus drive decoded from the current state; idle values outside a sequence.
    always_comb begin
        cs_n   = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        a_d    = 1'b1;
        ad_oe  = 1'b0;
        ad_out = 8'h00;
        case (state_q)
            S_ADDR_SETUP, S_ADDR_STROBE, S_ADDR_HOLD: begin
                cs_n   = 1'b0;
                a_d    = 1'b0;
                ad_oe  = 1'b1;
                ad_out = xfer_q ? ADDR_XFER : addr_of(idx_q);
                wr_n   = (state_q != S_ADDR_STROBE);
            end
            S_DATA_SETUP, S_DATA_STROBE, S_DATA_HOLD: begin
                cs_n = 1'b0;
                a_d  = 1'b1;
                if (op_rd_q) begin
                    rd_n = (state_q != S_DATA_STROBE);
                end else begin
                    ad_oe  = 1'b1;
                    ad_out = wdata_q[idx_q];
                    wr_n   = (state_q != S_DATA_STROBE);
                end
            end
            default: ;
        endcase
    end

    assign listo_es  = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

    assign segle  = rb_q[0];
    assign minle  = rb_q[1];
    assign horale = rb_q[2];
    assign diale  = rb_q[3];
    assign mesle  = rb_q[4];
    assign anole  = rb_q[5];
    assign stle   = rb_q[6];
    assign mtle   = rb_q[7];
    assign htle   = rb_q[8];

endmodule
